// File: rtl/vga_greyscale_pipe_pkg.sv
// vga_greyscale_pipe_pkg: mode/tint encodings and Q8 luma coefficients shared by the greyscale pipe.
package vga_greyscale_pipe_pkg;
    localparam logic [1:0] MODE_601 = 2'b00;
    localparam logic [1:0] MODE_709 = 2'b01;
    localparam logic [1:0] MODE_AVG = 2'b10;
    localparam logic [1:0] MODE_GRN = 2'b11;
    localparam logic [1:0] TINT_WHITE = 2'b00;
    localparam logic [1:0] TINT_GREEN = 2'b01;
    localparam logic [1:0] TINT_AMBER = 2'b10;
    localparam logic [1:0] TINT_WHITE_ALT = 2'b11;
    localparam logic [8:0] K601_R = 9'd77;
    localparam logic [8:0] K601_G = 9'd150;
    localparam logic [8:0] K601_B = 9'd29;
    localparam logic [8:0] K709_R = 9'd54;
    localparam logic [8:0] K709_G = 9'd183;
    localparam logic [8:0] K709_B = 9'd19;
    localparam logic [8:0] KAVG_R = 9'd85;
    localparam logic [8:0] KAVG_G = 9'd86;
    localparam logic [8:0] KAVG_B = 9'd85;
    localparam logic [8:0] KGRN_R = 9'd0;
    localparam logic [8:0] KGRN_G = 9'd256;
    localparam logic [8:0] KGRN_B = 9'd0;
    localparam int ROUND_Q8 = 128;
    typedef struct packed {
        logic [8:0] kr;
        logic [8:0] kg;
        logic [8:0] kb;
    } coef_t;
endpackage

// File: rtl/vga_greyscale_pipe_coef_rom.sv
// vga_grey_coef_rom: combinational mode -> Q8 {Kr,Kg,Kb} lookup; every set sums to 256.
module vga_grey_coef_rom
    import vga_greyscale_pipe_pkg::*;
(
    input  logic [1:0] i_mode,
    output coef_t      o_coef
);
    always_comb begin
        o_coef = i_mode == MODE_601 ? coef_t'{K601_R, K601_G, K601_B} :
                 i_mode == MODE_709 ? coef_t'{K709_R, K709_G, K709_B} :
                 i_mode == MODE_AVG ? coef_t'{KAVG_R, KAVG_G, KAVG_B} :
                                      coef_t'{KGRN_R, KGRN_G, KGRN_B};
    end
endmodule

// File: rtl/vga_greyscale_pipe.sv
// vga_greyscale_pipe: 3-stage RGB->luma converter with frame-aligned config and delayed sideband.
// Optional tint_in (white/green/amber) when GREY_TINT_EN is defined.
module vga_greyscale_pipe
    import vga_greyscale_pipe_pkg::*;
#(
    parameter int CW   = 10,
    parameter int SB_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_in,
    input  logic [1:0]      mode_in,
`ifdef GREY_TINT_EN
    input  logic [1:0]      tint_in,
`endif
    input  logic            frame_start_in,
    input  logic            valid_in,
    input  logic [CW-1:0]   r_in,
    input  logic [CW-1:0]   g_in,
    input  logic [CW-1:0]   b_in,
    input  logic [SB_W-1:0] sb_in,
    output logic            valid_out,
    output logic [CW-1:0]   r_out,
    output logic [CW-1:0]   g_out,
    output logic [CW-1:0]   b_out,
    output logic [CW-1:0]   y_out,
    output logic [SB_W-1:0] sb_out
);
    localparam int PW = CW + 9;
    localparam int SW = CW + 10;

    logic            r_cfg_en;
    logic [1:0]      r_cfg_mode;
    logic            w_en;
    logic [1:0]      w_mode;
    coef_t           w_coef;
    logic            r_s1_v, r_s2_v;
    logic            r_s1_en, r_s2_en;
    logic [SB_W-1:0] r_s1_sb, r_s2_sb;
    logic [CW-1:0]   r_s1_r, r_s1_g, r_s1_b, r_s2_r, r_s2_g, r_s2_b;
    logic [PW-1:0]   r_s1_pr, r_s1_pg, r_s1_pb;
    logic [SW-1:0]   r_s2_sum;
    logic [CW+1:0]   w_y_full;
    logic [CW-1:0]   w_y, w_tr, w_tg, w_tb;

    // The frame-start pixel already uses the config being loaded on that clock.
    assign w_en   = frame_start_in ? en_in : r_cfg_en;
    assign w_mode = frame_start_in ? mode_in : r_cfg_mode;

    vga_grey_coef_rom u_rom (
        .i_mode (w_mode),
        .o_coef (w_coef)
    );

`ifdef GREY_TINT_EN
    logic [1:0] r_cfg_tint, r_s1_tint, r_s2_tint;
    logic [1:0] w_tint;
    assign w_tint = frame_start_in ? tint_in : r_cfg_tint;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_tint <= TINT_WHITE;
            r_s1_tint  <= TINT_WHITE;
            r_s2_tint  <= TINT_WHITE;
        end else begin
            r_cfg_tint <= w_tint;
            r_s1_tint  <= w_tint;
            r_s2_tint  <= r_s1_tint;
        end
    end
    always_comb begin
        w_tr = r_s2_tint == TINT_GREEN ? w_y >> 2 : w_y;
        w_tg = r_s2_tint == TINT_AMBER ? w_y - (w_y >> 2) : w_y;
        w_tb = r_s2_tint == TINT_GREEN ? w_y >> 2 : r_s2_tint == TINT_AMBER ? '0 : w_y;
    end
`else
    always_comb begin
        w_tr = w_y;
        w_tg = w_y;
        w_tb = w_y;
    end
`endif

    assign w_y_full = r_s2_sum[SW-1:8];
    assign w_y      = |w_y_full[CW+1:CW] ? {CW{1'b1}} : w_y_full[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_en   <= 1'b0;
            r_cfg_mode <= MODE_601;
            r_s1_v     <= 1'b0;
            r_s1_en    <= 1'b0;
            r_s1_sb    <= '0;
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
            r_s1_pr    <= '0;
            r_s1_pg    <= '0;
            r_s1_pb    <= '0;
            r_s2_v     <= 1'b0;
            r_s2_en    <= 1'b0;
            r_s2_sb    <= '0;
            r_s2_r     <= '0;
            r_s2_g     <= '0;
            r_s2_b     <= '0;
            r_s2_sum   <= '0;
            valid_out  <= 1'b0;
            sb_out     <= '0;
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
            y_out      <= '0;
        end else begin
            r_cfg_en   <= w_en;
            r_cfg_mode <= w_mode;
            r_s1_v     <= valid_in;
            r_s1_en    <= w_en;
            r_s1_sb    <= sb_in;
            r_s1_r     <= r_in;
            r_s1_g     <= g_in;
            r_s1_b     <= b_in;
            r_s1_pr    <= PW'(r_in) * PW'(w_coef.kr);
            r_s1_pg    <= PW'(g_in) * PW'(w_coef.kg);
            r_s1_pb    <= PW'(b_in) * PW'(w_coef.kb);
            r_s2_v     <= r_s1_v;
            r_s2_en    <= r_s1_en;
            r_s2_sb    <= r_s1_sb;
            r_s2_r     <= r_s1_r;
            r_s2_g     <= r_s1_g;
            r_s2_b     <= r_s1_b;
            r_s2_sum   <= SW'(r_s1_pr) + SW'(r_s1_pg) + SW'(r_s1_pb) + SW'(ROUND_Q8);
            valid_out  <= r_s2_v;
            sb_out     <= r_s2_sb;
            y_out      <= r_s2_v ? w_y : '0;
            r_out      <= !r_s2_v ? '0 : r_s2_en ? w_tr : r_s2_r;
            g_out      <= !r_s2_v ? '0 : r_s2_en ? w_tg : r_s2_g;
            b_out      <= !r_s2_v ? '0 : r_s2_en ? w_tb : r_s2_b;
        end
    end
endmodule

// File: tb/tb_vga_greyscale_pipe.sv
// tb_vga_greyscale_pipe: directed vectors with hand-computed luma for CW=10, SB_W=3.
module tb_vga_greyscale_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_in = 1'b0;
    logic [1:0] mode_in = 2'b00;
`ifdef GREY_TINT_EN
    logic [1:0] tint_in = 2'b00;
`endif
    logic       frame_start_in = 1'b0;
    logic       valid_in = 1'b0;
    logic [9:0] r_in = '0, g_in = '0, b_in = '0;
    logic [2:0] sb_in = '0;
    logic       valid_out;
    logic [9:0] r_out, g_out, b_out, y_out;
    logic [2:0] sb_out;
    int total = 0;
    int bad = 0;

    vga_greyscale_pipe #(.CW(10), .SB_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_in          (en_in),
        .mode_in        (mode_in),
`ifdef GREY_TINT_EN
        .tint_in        (tint_in),
`endif
        .frame_start_in (frame_start_in),
        .valid_in       (valid_in),
        .r_in           (r_in),
        .g_in           (g_in),
        .b_in           (b_in),
        .sb_in          (sb_in),
        .valid_out      (valid_out),
        .r_out          (r_out),
        .g_out          (g_out),
        .b_out          (b_out),
        .y_out          (y_out),
        .sb_out         (sb_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input logic v, input int r, input int g, input int b, input int y);
        chk({tag, "_valid"}, 32'(valid_out), 32'(v));
        chk({tag, "_r"}, 32'(r_out), r);
        chk({tag, "_g"}, 32'(g_out), g);
        chk({tag, "_b"}, 32'(b_out), b);
        chk({tag, "_y"}, 32'(y_out), y);
    endtask

    task automatic drive(input logic fs, input logic en, input logic [1:0] mode, input logic v,
                         input int r, input int g, input int b, input logic [2:0] sb);
        frame_start_in = fs;
        en_in = en;
        mode_in = mode;
        valid_in = v;
        r_in = 10'(r);
        g_in = 10'(g);
        b_in = 10'(b);
        sb_in = sb;
    endtask

    task automatic idle;
        frame_start_in = 1'b0;
        valid_in = 1'b0;
        r_in = '0;
        g_in = '0;
        b_in = '0;
        sb_in = '0;
    endtask

    task automatic send(input logic fs, input logic en, input logic [1:0] mode, input logic v,
                        input int r, input int g, input int b, input logic [2:0] sb);
        drive(fs, en, mode, v, r, g, b, sb);
        tick;
        idle;
        tick;
        tick;
    endtask

    initial begin
        tick;
        chk_px("reset", 1'b0, 0, 0, 0, 0);
        chk("reset_sb", 32'(sb_out), 0);
        #2 rst_n = 1'b1;
        tick;

        // BT.601 single-channel maxima: red then green back-to-back
        drive(1'b1, 1'b1, 2'b00, 1'b1, 1023, 0, 0, 3'b000);
        tick;
        drive(1'b0, 1'b1, 2'b00, 1'b1, 0, 1023, 0, 3'b000);
        tick;
        idle;
        tick;
        chk_px("p601_red", 1'b1, 308, 308, 308, 308);
        tick;
        chk_px("p601_green", 1'b1, 599, 599, 599, 599);
        tick;
        chk_px("after_burst", 1'b0, 0, 0, 0, 0);

        for (int m = 0; m < 4; m++) begin
            send(1'b1, 1'b1, 2'(m), 1'b1, 1023, 1023, 1023, 3'b000);
            chk($sformatf("white_m%0d_y", m), 32'(y_out), 1023);
            chk($sformatf("white_m%0d_r", m), 32'(r_out), 1023);
        end
        send(1'b1, 1'b1, 2'b01, 1'b1, 0, 0, 0, 3'b000);
        chk_px("black", 1'b1, 0, 0, 0, 0);

        // Latency: one-cycle valid + sideband pulse
        drive(1'b0, 1'b1, 2'b00, 1'b1, 0, 0, 0, 3'b101);
        tick;
        idle;
        tick;
        chk("lat_early_valid", 32'(valid_out), 0);
        chk("lat_early_sb", 32'(sb_out), 0);
        tick;
        chk("lat_valid", 32'(valid_out), 1);
        chk("lat_sb", 32'(sb_out), 5);
        tick;
        chk("lat_late_valid", 32'(valid_out), 0);
        chk("lat_late_sb", 32'(sb_out), 0);

        send(1'b0, 1'b1, 2'b00, 1'b0, 500, 600, 700, 3'b010);
        chk_px("blank", 1'b0, 0, 0, 0, 0);
        chk("blank_sb", 32'(sb_out), 2);

        // Config shadow: 709 request ignored until frame start, then applied on that exact pixel
        send(1'b1, 1'b1, 2'b00, 1'b1, 1023, 0, 0, 3'b000);
        chk("shadow_base_y", 32'(y_out), 308);
        drive(1'b0, 1'b1, 2'b01, 1'b1, 1023, 0, 0, 3'b000);
        tick;
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1023, 0, 0, 3'b000);
        tick;
        idle;
        tick;
        chk_px("shadow_hold", 1'b1, 308, 308, 308, 308);
        tick;
        chk_px("shadow_switch", 1'b1, 216, 216, 216, 216);

        send(1'b1, 1'b0, 2'b00, 1'b1, 100, 200, 300, 3'b000);
        chk_px("passthru", 1'b1, 100, 200, 300, 181);

`ifdef GREY_TINT_EN
        tint_in = 2'b10;
        send(1'b1, 1'b1, 2'b00, 1'b1, 400, 400, 400, 3'b000);
        chk_px("amber", 1'b1, 400, 300, 0, 400);
        tint_in = 2'b00;
`else
        send(1'b1, 1'b1, 2'b00, 1'b1, 400, 400, 400, 3'b000);
        chk_px("grey400", 1'b1, 400, 400, 400, 400);
`endif

        // Asynchronous reset with the pipe full
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1023, 0, 0, 3'b111);
        tick;
        drive(1'b0, 1'b1, 2'b01, 1'b1, 1023, 0, 0, 3'b111);
        tick;
        tick;
        chk_px("prereset", 1'b1, 216, 216, 216, 216);
        #2 rst_n = 1'b0;
        #1;
        chk_px("async_rst", 1'b0, 0, 0, 0, 0);
        chk("async_rst_sb", 32'(sb_out), 0);
        #1 rst_n = 1'b1;
        idle;
        tick;
        send(1'b0, 1'b1, 2'b01, 1'b1, 100, 200, 300, 3'b000);
        chk_px("post_rst", 1'b1, 100, 200, 300, 181);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
